// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default parameters for the button debouncer
package debounce_pkg;
   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      PRESS_WAIT   = 2'b01,
      HELD         = 2'b10,
      RELEASE_WAIT = 2'b11
   } state_e;
   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_REPEAT_DELAY    = 50000000;
   localparam int DEF_REPEAT_PERIOD   = 10000000;
   localparam int DEF_CNT_WIDTH       = 32;
endpackage

// File: rtl/button_debouncer_if.sv
// button_debouncer_if: raw button input and debounced level/pulse outputs
interface button_debouncer_if;
   logic button_raw_i;
   logic level_o;
   logic press_o;
   logic release_o;
   logic repeat_o;
   logic step_o;
   modport master (output button_raw_i, input level_o, press_o, release_o, repeat_o, step_o);
   modport slave  (input button_raw_i, output level_o, press_o, release_o, repeat_o, step_o);
endinterface

// File: rtl/button_debouncer_sync.sv
// input_synchronizer: two-flop synchronizer bringing the raw pad into the clock domain
module input_synchronizer (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);
   logic s1_q, s2_q;
   // shift the asynchronous input through two flops to settle metastability
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end
   assign q_o = s2_q;
endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: debounces a push-button into a clean level plus press/release/repeat/step pulses
module button_debouncer
   import debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
   input logic          clock,
   input logic          reset,
   button_debouncer_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] REP_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] REP_WRAP = CNT_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD);
   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] deb_cnt_q, deb_cnt_d, rep_cnt_q, rep_cnt_d;
   logic                 level_q, level_d, press_q, press_d, release_q, release_d;
   logic                 repeat_q, repeat_d, step_q, btn_s;
   input_synchronizer u_sync (
      .clock (clock),
      .reset (reset),
      .d_i   (bus.button_raw_i),
      .q_o   (btn_s)
   );
   // register FSM state, counters and all outputs; reset aborts silently
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         deb_cnt_q <= '0;
         rep_cnt_q <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
         step_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         deb_cnt_q <= deb_cnt_d;
         rep_cnt_q <= rep_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
         step_q    <= press_d | repeat_d;
      end
   end
   // next state: counters qualify level changes, rep_cnt freezes outside HELD and wraps to keep the period
   always_comb begin
      state_d   = state_q;
      deb_cnt_d = deb_cnt_q;
      rep_cnt_d = rep_cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         IDLE: begin
            level_d   = 1'b0;
            state_d   = btn_s ? PRESS_WAIT : IDLE;
            deb_cnt_d = btn_s ? ONE : '0;
         end
         PRESS_WAIT: begin
            if (!btn_s) begin
               state_d   = IDLE;
               deb_cnt_d = '0;
            end else if (deb_cnt_q == DEB_LAST) begin
               state_d   = HELD;
               level_d   = 1'b1;
               press_d   = 1'b1;
               rep_cnt_d = '0;
            end else deb_cnt_d = deb_cnt_q + ONE;
         end
         HELD: begin
            if (!btn_s) begin
               state_d   = RELEASE_WAIT;
               deb_cnt_d = ONE;
            end else if (REPEAT_DELAY == 0) rep_cnt_d = '0;
            else if (rep_cnt_q == REP_LAST) begin
               repeat_d  = 1'b1;
               rep_cnt_d = REP_WRAP;
            end else rep_cnt_d = rep_cnt_q + ONE;
         end
         RELEASE_WAIT: begin
            if (btn_s) state_d = HELD;
            else if (deb_cnt_q == DEB_LAST) begin
               state_d   = IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else deb_cnt_d = deb_cnt_q + ONE;
         end
         default: begin
            state_d   = IDLE;
            level_d   = 1'b0;
            deb_cnt_d = '0;
            rep_cnt_d = '0;
         end
      endcase
   end
   assign bus.level_o   = level_q;
   assign bus.press_o   = press_q;
   assign bus.release_o = release_q;
   assign bus.repeat_o  = repeat_q;
   assign bus.step_o    = step_q;
endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: scoreboard bench for button_debouncer with short debounce/repeat timing
module tb_button_debouncer;
   localparam int DC = 4, RD = 10, RP = 5;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   errors = 0, checks = 0;
   logic [4:0] sb[$];
   logic       raw_q[$];
   button_debouncer_if bif ();
   button_debouncer #(
      .DEBOUNCE_CYCLES (DC),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .CNT_WIDTH       (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif)
   );
   always #5 clock = ~clock;
   // expected output vector {level, press, release, repeat, step}
   function automatic logic [4:0] ev(input bit l, input bit p, input bit r, input bit rp);
      return {l, p, r, rp, p | rp};
   endfunction
   function automatic logic [4:0] obs();
      return {bif.level_o, bif.press_o, bif.release_o, bif.repeat_o, bif.step_o};
   endfunction
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic push(input bit raw, input logic [4:0] e);
      raw_q.push_back(raw);
      sb.push_back(e);
   endtask
   task automatic do_reset();
      reset = 1'b0;
      bif.button_raw_i = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask
   task automatic test_reset();
      logic [4:0] e;
      int n = 1;
      reset = 1'b0;
      for (int i = 1; i <= 5; i++) push(1'b1, 5'b0);
      while (sb.size() > 0) begin
         bif.button_raw_i = raw_q.pop_front();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL reset_hold edge %0d: got %b want %b", n, obs(), e);
         end
         n++;
      end
      reset = 1'b1;
      n = 1;
      for (int i = 1; i <= 8; i++) push(1'b1, ev(i >= 6, i == 6, 0, 0));
      while (sb.size() > 0) begin
         bif.button_raw_i = raw_q.pop_front();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL reset_release edge %0d: got %b want %b", n, obs(), e);
         end
         n++;
      end
   endtask
   task automatic test_clean_press();
      logic [4:0] e;
      int n = 1;
      do_reset();
      for (int i = 1; i <= 9; i++) push(1'b1, ev(i >= 6, i == 6, 0, 0));
      while (sb.size() > 0) begin
         bif.button_raw_i = raw_q.pop_front();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL clean_press edge %0d: got %b want %b", n, obs(), e);
         end
         n++;
      end
   endtask
   task automatic test_bounce();
      logic [4:0] e;
      int n = 1;
      do_reset();
      for (int i = 1; i <= 24; i++) push(i <= 4 ? bit'(i % 2) : 1'b0, 5'b0);
      while (sb.size() > 0) begin
         bif.button_raw_i = raw_q.pop_front();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL bounce edge %0d: got %b want %b", n, obs(), e);
         end
         n++;
      end
   endtask
   task automatic test_auto_repeat();
      logic [4:0] e;
      int n = 1;
      do_reset();
      for (int i = 1; i <= 36; i++)
         push(1'b1, ev(i >= 6, i == 6, 0, i >= 16 && (i - 16) % RP == 0));
      while (sb.size() > 0) begin
         bif.button_raw_i = raw_q.pop_front();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL auto_repeat edge %0d: got %b want %b", n, obs(), e);
         end
         n++;
      end
   endtask
   task automatic test_release_bounce();
      logic [4:0] e;
      int n = 1;
      do_reset();
      for (int i = 1; i <= 24; i++)
         push(i <= 8 || i == 11, ev(i >= 6 && i < 17, i == 6, i == 17, 0));
      while (sb.size() > 0) begin
         bif.button_raw_i = raw_q.pop_front();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL release_bounce edge %0d: got %b want %b", n, obs(), e);
         end
         n++;
      end
   endtask
   task automatic test_reset_mid_hold();
      logic [4:0] e;
      int n = 1;
      do_reset();
      for (int i = 1; i <= 13; i++) push(1'b1, ev(i >= 6, i == 6, 0, 0));
      while (sb.size() > 0) begin
         bif.button_raw_i = raw_q.pop_front();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL mid_hold_pre edge %0d: got %b want %b", n, obs(), e);
         end
         n++;
      end
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if (obs() !== 5'b0) begin
         errors++;
         $display("FAIL mid_hold_async: got %b want %b", obs(), 5'b0);
      end
      @(negedge clock);
      n = 1;
      for (int i = 1; i <= 2; i++) push(1'b1, 5'b0);
      while (sb.size() > 0) begin
         bif.button_raw_i = raw_q.pop_front();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL mid_hold_in_reset edge %0d: got %b want %b", n, obs(), e);
         end
         n++;
      end
      reset = 1'b1;
      n = 1;
      for (int i = 1; i <= 4; i++) push(1'b0, 5'b0);
      for (int i = 1; i <= 8; i++) push(1'b1, ev(i >= 6, i == 6, 0, 0));
      while (sb.size() > 0) begin
         bif.button_raw_i = raw_q.pop_front();
         tick();
         e = sb.pop_front();
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL mid_hold_after edge %0d: got %b want %b", n, obs(), e);
         end
         n++;
      end
   endtask
   initial begin
      bif.button_raw_i = 1'b0;
      #2;
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto_repeat();
      test_release_bounce();
      test_reset_mid_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
